countdown_timer_ctrl: RTL and testbench

COUNTDOWN_TIMER_CTRL -- requirements
Module: countdown_timer_ctrl

---
 rtl/countdown_timer_ctrl_pkg.sv | 18 +
 rtl/countdown_timer_ctrl_prescaler.sv | 41 ++++
 rtl/countdown_timer_ctrl.sv | 128 ++++++++++++
 tb/tb_countdown_timer_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/countdown_timer_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// countdown_timer_ctrl_pkg
// Shared definitions for the countdown timer block:
//   - timer_state_e : controller state encoding (IDLE/RUN/PAUSE)
//   - TIMER_WIDTH_DEFAULT / TIMER_PRESCALE_DEFAULT : default parameter values
// ---------------------------------------------------------------------------
package countdown_timer_ctrl_pkg;

  localparam int TIMER_WIDTH_DEFAULT    = 4;
  localparam int TIMER_PRESCALE_DEFAULT = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } timer_state_e;

endpackage

// File: rtl/countdown_timer_ctrl_prescaler.sv
// ---------------------------------------------------------------------------
// timer_prescaler
// Divides Clk into count ticks. The internal counter runs 0..PRESCALE-1 while
// En is high and holds its value while En is low.
// Ports:
//   Clk   in  clock
//   ClrN  in  asynchronous active-low reset
//   En    in  advance the counter this cycle
//   Clr   in  synchronous clear to 0 (wins over En)
//   Tick  out high in the cycle whose edge completes a prescale period
// ---------------------------------------------------------------------------
module timer_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic Clk,
  input  logic ClrN,
  input  logic En,
  input  logic Clr,
  output logic Tick
);

  localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_q;

  // Combinational so the controller sees the tick on the same edge the
  // counter wraps.
  assign Tick = En && (cnt_q == LAST);

  always_ff @(posedge Clk or negedge ClrN) begin
    if (!ClrN) begin
      cnt_q <= '0;
    end else if (Clr) begin
      cnt_q <= '0;
    end else if (En) begin
      cnt_q <= Tick ? '0 : cnt_q + PW'(1);
    end
  end

endmodule

// File: rtl/countdown_timer_ctrl.sv
// ---------------------------------------------------------------------------
// countdown_timer_ctrl
// Loadable down-counter with prescaler, pause/resume and optional auto-reload.
// Ports:
//   Clk        in   clock (rising edge)
//   ClrN       in   asynchronous active-low reset
//   Start      in   start / resume counting
//   Stop       in   pause counting (priority over Start and a coincident tick)
//   Load       in   load LoadVal into Count and Reload (IDLE or PAUSE only)
//   LoadVal    in   preset value
//   AutoReload in   restart from Reload on expiry instead of stopping
//   Count      out  registered counter value
//   Busy       out  state is RUN or PAUSE
//   Done       out  registered one-cycle expiry pulse
//   state_dbg  out  current state register
// Handshake: none; all control inputs are levels sampled on every rising edge.
// ---------------------------------------------------------------------------
module countdown_timer_ctrl
  import countdown_timer_ctrl_pkg::*;
#(
  parameter int WIDTH    = TIMER_WIDTH_DEFAULT,
  parameter int PRESCALE = TIMER_PRESCALE_DEFAULT
) (
  input  logic             Clk,
  input  logic             ClrN,
  input  logic             Start,
  input  logic             Stop,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  input  logic             AutoReload,
  output logic [WIDTH-1:0] Count,
  output logic             Busy,
  output logic             Done,
  output logic [1:0]       state_dbg
);

  timer_state_e     state_q, state_n;
  logic [WIDTH-1:0] count_q, count_n;
  logic [WIDTH-1:0] reload_q, reload_n;
  logic             done_q, done_n;
  logic             pre_en, pre_clr, tick;

  // Stop freezes the prescaler on the very edge it is sampled, so a tick
  // coinciding with Stop is suppressed. The prescaler is held at 0 in IDLE,
  // so every RUN entry from IDLE starts a fresh period.
  assign pre_en  = (state_q == ST_RUN) && !Stop;
  assign pre_clr = (state_q == ST_IDLE);

  timer_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .Clk  (Clk),
    .ClrN (ClrN),
    .En   (pre_en),
    .Clr  (pre_clr),
    .Tick (tick)
  );

  always_ff @(posedge Clk or negedge ClrN) begin
    if (!ClrN) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      count_q  <= count_n;
      reload_q <= reload_n;
      done_q   <= done_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    count_n  = count_q;
    reload_n = reload_q;
    done_n   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Load wins over Start; starting from zero is meaningless.
        if (Load) begin
          count_n  = LoadVal;
          reload_n = LoadVal;
        end else if (Start && (count_q != '0)) begin
          state_n = ST_RUN;
        end
      end
      ST_RUN: begin
        if (Stop) begin
          state_n = ST_PAUSE;
        end else if (tick) begin
          if (count_q > WIDTH'(1)) begin
            count_n = count_q - WIDTH'(1);
          end else if (count_q == WIDTH'(1)) begin
            done_n = 1'b1;
            if (AutoReload) begin
              count_n = reload_q;
            end else begin
              count_n = '0;
              state_n = ST_IDLE;
            end
          end
          // count_q == 0 cannot occur in RUN; hold rather than wrap.
        end
      end
      ST_PAUSE: begin
        if (Load) begin
          count_n  = LoadVal;
          reload_n = LoadVal;
          if (LoadVal == '0) begin
            state_n = ST_IDLE;
          end
        end else if (Start && !Stop) begin
          state_n = ST_RUN;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  assign Count     = count_q;
  assign Done      = done_q;
  assign Busy      = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_countdown_timer_ctrl
// Two instances (PRESCALE=1 and PRESCALE=3) share one stimulus stream. The
// driver advances a reference model per instance and queues the expected
// {state, Busy, Done, Count}; a monitor pops and compares after each edge.
// ---------------------------------------------------------------------------
module tb_countdown_timer_ctrl;

  localparam int W  = 4;
  localparam int EW = 2 + 1 + 1 + W;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;

  // clock / reset
  logic Clk = 1'b0;
  logic ClrN = 1'b0;
  always #5 Clk = ~Clk;

  logic         Start = 1'b0, Stop = 1'b0, Load = 1'b0, AutoReload = 1'b0;
  logic [W-1:0] LoadVal = '0;

  logic [W-1:0] count_p1, count_p3;
  logic         busy_p1, busy_p3, done_p1, done_p3;
  logic [1:0]   state_p1, state_p3;

  countdown_timer_ctrl #(.WIDTH(W), .PRESCALE(1)) u_dut_p1 (
    .Clk(Clk), .ClrN(ClrN), .Start(Start), .Stop(Stop), .Load(Load),
    .LoadVal(LoadVal), .AutoReload(AutoReload), .Count(count_p1),
    .Busy(busy_p1), .Done(done_p1), .state_dbg(state_p1)
  );

  countdown_timer_ctrl #(.WIDTH(W), .PRESCALE(3)) u_dut_p3 (
    .Clk(Clk), .ClrN(ClrN), .Start(Start), .Stop(Stop), .Load(Load),
    .LoadVal(LoadVal), .AutoReload(AutoReload), .Count(count_p3),
    .Busy(busy_p3), .Done(done_p3), .state_dbg(state_p3)
  );

  // scoreboard
  logic [EW-1:0] exp_q1[$];
  logic [EW-1:0] exp_q3[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got{st,busy,done,cnt}=%h required=%h", name, $time, got, exp);
    end
  endtask

  // reference model: one entry per instance
  int m_pres[2] = '{1, 3};
  int m_mode[2];
  int m_count[2];
  int m_reload[2];
  int m_phase[2];   // clocks elapsed in the current tick period

  function automatic logic [EW-1:0] pack_exp(input int mode, input int done, input int cnt);
    logic [1:0]   s;
    logic [W-1:0] c;
    s = 2'(mode);
    c = W'(cnt);
    return {s, (mode != M_IDLE), (done != 0), c};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = M_IDLE; m_count[k] = 0; m_reload[k] = 0; m_phase[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input bit st, input bit sp, input bit ld,
                            input int lv, input bit ar, output logic [EW-1:0] e);
    int done;
    done = 0;
    if (m_mode[k] == M_IDLE) begin
      m_phase[k] = 0;
      if (ld) begin
        m_count[k] = lv; m_reload[k] = lv;
      end else if (st && m_count[k] != 0) begin
        m_mode[k] = M_RUN;
      end
    end else if (m_mode[k] == M_RUN) begin
      if (sp) begin
        m_mode[k] = M_PAUSE;
      end else begin
        m_phase[k] = m_phase[k] + 1;
        if (m_phase[k] == m_pres[k]) begin
          m_phase[k] = 0;
          if (m_count[k] > 1) begin
            m_count[k] = m_count[k] - 1;
          end else if (m_count[k] == 1) begin
            done = 1;
            if (ar) m_count[k] = m_reload[k];
            else begin
              m_count[k] = 0; m_mode[k] = M_IDLE;
            end
          end
        end
      end
    end else begin
      if (ld) begin
        m_count[k] = lv; m_reload[k] = lv;
        if (lv == 0) m_mode[k] = M_IDLE;
      end else if (st && !sp) begin
        m_mode[k] = M_RUN;
      end
    end
    e = pack_exp(m_mode[k], done, m_count[k]);
  endtask

  // driver: one call = one clock cycle of stimulus
  task automatic cyc(input bit st, input bit sp, input bit ld, input int lv,
                     input bit ar, input bit rst);
    logic [EW-1:0] e;
    @(negedge Clk);
    Start = st; Stop = sp; Load = ld; LoadVal = W'(lv); AutoReload = ar;
    if (rst) begin
      ClrN = 1'b0;
      #1;
      chk("async_reset_p1", {state_p1, busy_p1, done_p1, count_p1}, '0);
      chk("async_reset_p3", {state_p3, busy_p3, done_p3, count_p3}, '0);
      model_reset();
      exp_q1.push_back('0);
      exp_q3.push_back('0);
    end else begin
      ClrN = 1'b1;
      model_step(0, st, sp, ld, lv, ar, e); exp_q1.push_back(e);
      model_step(1, st, sp, ld, lv, ar, e); exp_q3.push_back(e);
    end
  endtask

  task automatic idle_cycles(input int n, input bit ar);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, ar, 0);
  endtask

  // monitor
  always @(posedge Clk) begin
    logic [EW-1:0] e;
    #1;
    if (exp_q1.size() > 0) begin
      e = exp_q1.pop_front();
      chk("out_p1", {state_p1, busy_p1, done_p1, count_p1}, e);
    end
    if (exp_q3.size() > 0) begin
      e = exp_q3.pop_front();
      chk("out_p3", {state_p3, busy_p3, done_p3, count_p3}, e);
    end
  end

  initial begin
    model_reset();
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);

    // load 3, start, plain countdown to expiry
    cyc(0, 0, 1, 3, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    idle_cycles(12, 0);

    // load 2, start, prescaled timing
    cyc(0, 0, 1, 2, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    idle_cycles(8, 0);

    // load 2 with auto-reload, then stop and load 0 in pause
    cyc(0, 0, 1, 2, 1, 0);
    cyc(1, 0, 0, 0, 1, 0);
    idle_cycles(12, 1);
    cyc(0, 1, 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 1, 0);
    idle_cycles(2, 0);

    // load 9, stop at 6, hold, stop+start, resume
    cyc(0, 0, 1, 9, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20 && m_count[0] != 6; i++) cyc(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    idle_cycles(40, 0);

    // load 15, reset in the middle of the run
    cyc(0, 0, 1, 15, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20 && m_count[0] != 8; i++) cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    idle_cycles(3, 0);

    // start with count 0, then load in pause, load+start in pause
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 9, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    idle_cycles(2, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 5, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 7, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 4, 0, 0);
    idle_cycles(30, 0);

    // randomized traffic
    begin
      bit ar;
      ar = 1'b0;
      for (int i = 0; i < 1500; i++) begin
        if ($urandom_range(0, 49) == 0) ar = ~ar;
        cyc($urandom_range(0, 99) < 25, $urandom_range(0, 99) < 8,
            $urandom_range(0, 99) < 10, int'($urandom_range(0, 15)), ar,
            $urandom_range(0, 199) == 0);
      end
    end

    @(posedge Clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
